// File: rtl/montexp_pkg.sv
// Shared defaults and FSM state encoding for the Montgomery exponentiator.
package montexp_pkg;

    localparam int unsigned NDefault      = 1024;
    localparam int unsigned EWidthDefault = 1024;

    typedef enum logic [3:0] {
        StIdle,
        StSqStart,
        StSqWait,
        StMulStart,
        StMulWait,
        StNext,
        StFinStart,
        StFinWait,
        StDone
    } state_e;

endpackage

// File: rtl/montexp_bitscan.sv
// Exponent shift register (MSB first) with a non-wrapping bit-index down-counter.
// With MONTEXP_SKIP_LEADING_ZEROS_EN defined, also flags leading zero bits for skipping.
module montexp_bitscan
    import montexp_pkg::*;
#(
    parameter int unsigned E_WIDTH = EWidthDefault
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [E_WIDTH-1:0] e,
    output logic               cur_bit,
    output logic               last,
    output logic               skip
);

    localparam int unsigned     CntW   = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [CntW-1:0] IdxTop = CntW'(E_WIDTH - 1);

    logic [E_WIDTH-1:0] e_q;
    logic [CntW-1:0]    idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            idx_q <= '0;
        end else if (load) begin
            e_q   <= e;
            idx_q <= IdxTop;
        end else if (shift && idx_q != '0) begin
            e_q   <= e_q << 1;
            idx_q <= idx_q - CntW'(1);
        end
    end

    assign cur_bit = e_q[E_WIDTH-1];
    assign last    = (idx_q == '0);

`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
    // Set once the first 1 bit has been consumed; zeros after it are real squarings.
    logic found_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            found_q <= 1'b0;
        end else if (shift) begin
            found_q <= found_q | cur_bit;
        end
    end

    assign skip = ~found_q & ~cur_bit;
`else
    assign skip = 1'b0;
`endif

endmodule

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply modular exponentiation driving an external Montgomery
// multiplier. Optional macro MONTEXP_SKIP_LEADING_ZEROS_EN skips leading exponent zeros.
module montgomery_exp
    import montexp_pkg::*;
#(
    parameter int unsigned N       = NDefault,
    parameter int unsigned E_WIDTH = EWidthDefault
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N-1:0]       in_x,
    input  logic [N-1:0]       in_r,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [N-1:0]       in_m,
    output logic [N-1:0]       result,
    output logic               done,
    output logic               mm_start,
    output logic [N-1:0]       mm_a,
    output logic [N-1:0]       mm_b,
    output logic [N-1:0]       mm_m,
    input  logic [N-1:0]       mm_result,
    input  logic               mm_done
);

    state_e       state_q, state_d;
    logic [N-1:0] a_q, x_q, m_q, res_q;
    logic         bs_load, bs_shift, cur_bit, last, skip;
    logic         capture;

    assign bs_load = (state_q == StIdle) && start;

    montexp_bitscan #(
        .E_WIDTH (E_WIDTH)
    ) u_bitscan (
        .clk     (clk),
        .reset   (reset),
        .load    (bs_load),
        .shift   (bs_shift),
        .e       (in_e),
        .cur_bit (cur_bit),
        .last    (last),
        .skip    (skip)
    );

    // Operands are pure functions of state and registers that only change on mm_done,
    // so they stay put for the whole START/WAIT window.
    always_comb begin
        state_d  = state_q;
        bs_shift = 1'b0;
        mm_start = 1'b0;
        mm_a     = '0;
        mm_b     = '0;
        mm_m     = '0;
        done     = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StSqStart;
            end
            StSqStart: begin
                mm_a = a_q;
                mm_b = a_q;
                mm_m = m_q;
                if (skip) begin
                    if (last) state_d = StFinStart;
                    else bs_shift = 1'b1;
                end else begin
                    mm_start = 1'b1;
                    state_d  = StSqWait;
                end
            end
            StSqWait: begin
                mm_a    = a_q;
                mm_b    = a_q;
                mm_m    = m_q;
                capture = mm_done;
                if (mm_done) state_d = cur_bit ? StMulStart : StNext;
            end
            StMulStart: begin
                mm_a     = a_q;
                mm_b     = x_q;
                mm_m     = m_q;
                mm_start = 1'b1;
                state_d  = StMulWait;
            end
            StMulWait: begin
                mm_a    = a_q;
                mm_b    = x_q;
                mm_m    = m_q;
                capture = mm_done;
                if (mm_done) state_d = StNext;
            end
            StNext: begin
                if (last) begin
                    state_d = StFinStart;
                end else begin
                    bs_shift = 1'b1;
                    state_d  = StSqStart;
                end
            end
            StFinStart: begin
                mm_a     = a_q;
                mm_b     = N'(1);
                mm_m     = m_q;
                mm_start = 1'b1;
                state_d  = StFinWait;
            end
            StFinWait: begin
                mm_a    = a_q;
                mm_b    = N'(1);
                mm_m    = m_q;
                capture = mm_done;
                if (mm_done) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            x_q     <= '0;
            m_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (bs_load) begin
                a_q <= in_r;
                x_q <= in_x;
                m_q <= in_m;
            end else if (capture) begin
                a_q <= mm_result;
            end
            if (capture && state_q == StFinWait) res_q <= mm_result;
        end
    end

    assign result = res_q;

endmodule

// File: tb/tb_montgomery_exp.sv
// Directed bench for montgomery_exp with a behavioural latency-7 Montgomery multiplier.
module tb_montgomery_exp;

    localparam int unsigned N   = 1024;
    localparam int unsigned EW  = 1024;
    localparam int          Lat = 7;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [N-1:0]  in_x, in_r, in_m, result, mm_a, mm_b, mm_m;
    logic [N-1:0]  mm_result = '0;
    logic [EW-1:0] in_e;
    logic          done, mm_start;
    logic          mm_done = 1'b0;

    always #5 clk = ~clk;

    montgomery_exp #(
        .N       (N),
        .E_WIDTH (EW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_x      (in_x),
        .in_r      (in_r),
        .in_e      (in_e),
        .in_m      (in_m),
        .result    (result),
        .done      (done),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done)
    );

    // Bit-serial Montgomery product a*b*2^-N mod m.
    function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m);
        logic [N+1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[N-1:0];
    endfunction

    // Multiplier model plus operand-stability and event counters, all on the negedge.
    int           starts_total = 0;
    int           done_total   = 0;
    int           stab_bad     = 0;
    int           lat_cnt      = 0;
    logic         op_live      = 1'b0;
    logic [N-1:0] op_a, op_b, op_m;

    always @(negedge clk) begin
        if (done) done_total++;
        if (reset) op_live = 1'b0;
        mm_done = 1'b0;
        if (lat_cnt > 0) begin
            if (op_live && (mm_a !== op_a || mm_b !== op_b || mm_m !== op_m)) stab_bad++;
            lat_cnt--;
            if (lat_cnt == 0) begin
                mm_done   = 1'b1;
                mm_result = mont(op_a, op_b, op_m);
            end
        end
        if (mm_start) begin
            starts_total++;
            op_a    = mm_a;
            op_b    = mm_b;
            op_m    = mm_m;
            op_live = 1'b1;
            lat_cnt = Lat;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0],
                     exp[127:0]);
        end
    endtask

    logic [N-1:0] m_c, r_c;

    // Starts a run in the current cycle, waits (bounded) for done, checks the pulse width.
    task automatic run_exp(input logic [N-1:0] xm, input logic [EW-1:0] e, input bit repulse,
                           output logic [N-1:0] res, output int nstarts, output int nstab);
        int  s0, b0;
        bit  timed_out;
        s0    = starts_total;
        b0    = stab_bad;
        start = 1'b1;
        in_x  = xm;
        in_r  = r_c;
        in_m  = m_c;
        in_e  = e;
        @(negedge clk);
        start = 1'b0;
        in_x  = ~xm;
        in_r  = '0;
        in_m  = '1;
        in_e  = ~e;
        timed_out = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            if (repulse && c == 20) start = 1'b1;
            if (repulse && c == 21) start = 1'b0;
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk("done_timeout", N'(timed_out), N'(0));
        res = result;
        @(negedge clk);
        chk("done_one_cycle", N'(done), N'(0));
        chk("result_hold", result, res);
        nstarts = starts_total - s0;
        nstab   = stab_bad - b0;
    endtask

    typedef struct {
        string         name;
        logic [N-1:0]  xm;
        logic [EW-1:0] e;
        logic [N-1:0]  exp_res;
        int            starts_plain;
        int            starts_skip;
    } vec_t;

    vec_t vecs[3];

    function automatic int exp_starts(input vec_t v);
`ifdef MONTEXP_SKIP_LEADING_ZEROS_EN
        return v.starts_skip;
`else
        return v.starts_plain;
`endif
    endfunction

    initial begin
        logic [N-1:0]  res;
        logic [EW-1:0] e_msb;
        int            nst, nsb, s0, s1, d0;
        vec_t          rv;

        // M = 2^1024 - 105, so R mod M = 105 and x*R mod M = 105*x for small x.
        m_c = '1;
        m_c = m_c - N'(104);
        r_c = N'(105);
        vecs[0] = '{"x3_e5", N'(315), EW'(5), N'(243), 1027, 6};
        vecs[1] = '{"e0", N'(315), EW'(0), N'(1), 1025, 1};
        vecs[2] = '{"xm1_e1", m_c - N'(105), EW'(1), m_c - N'(1), 1026, 3};

        reset = 1'b1;
        start = 1'b0;
        in_x  = '0;
        in_r  = '0;
        in_m  = '0;
        in_e  = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, N'(0));
        chk("rst_done", N'(done), N'(0));
        chk("rst_mm_start", N'(mm_start), N'(0));
        chk("rst_mm_ops", mm_a | mm_b | mm_m, N'(0));
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back runs: each starts the cycle right after the previous done.
        for (int i = 0; i < 3; i++) begin
            run_exp(vecs[i].xm, vecs[i].e, 1'b0, res, nst, nsb);
            chk({vecs[i].name, "_result"}, res, vecs[i].exp_res);
            chk({vecs[i].name, "_mm_starts"}, N'(nst), N'(exp_starts(vecs[i])));
            chk({vecs[i].name, "_ops_stable"}, N'(nsb), N'(0));
        end

        // Abort in MUL_WAIT: the in-flight product comes back as a stray mm_done in IDLE.
        e_msb         = '0;
        e_msb[EW-1]   = 1'b1;
        s0            = starts_total;
        start         = 1'b1;
        in_x          = N'(315);
        in_r          = r_c;
        in_m          = m_c;
        in_e          = e_msb;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (starts_total - s0 >= 2) break;
        end
        chk("abort_reached_mul", N'(starts_total - s0), N'(2));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        d0    = done_total;
        s1    = starts_total;
        chk("abort_mm_ops_zero", mm_a | mm_b | mm_m, N'(0));
        repeat (12) @(negedge clk);
        chk("abort_no_done", N'(done_total - d0), N'(0));
        chk("abort_idle_no_mm_start", N'(starts_total - s1), N'(0));
        chk("abort_result_cleared", result, N'(0));

        // Next run after the abort, with a stray start pulse mid-run: 2^10 = 1024.
        rv = '{"x2_e10", N'(210), EW'(10), N'(1024), 1027, 7};
        run_exp(rv.xm, rv.e, 1'b1, res, nst, nsb);
        chk("x2_e10_result", res, rv.exp_res);
        chk("x2_e10_mm_starts", N'(nst), N'(exp_starts(rv)));
        chk("x2_e10_ops_stable", N'(nsb), N'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
